// File: rtl/bp_me_lce_responder.sv
// Single-LCE coherence responder: sync handshake, then per-miss writeback/fill/ack
// against a local block memory. Optional counters under BP_ME_LCE_RESPONDER_STATS_EN.
module bp_me_lce_responder #(
  parameter int num_cce_p             = 1,
  parameter int num_lce_p             = 1,
  parameter int lce_id_p              = 0,
  parameter int paddr_width_p         = 40,
  parameter int lce_assoc_p           = 8,
  parameter int block_size_in_bytes_p = 64,
  parameter int mem_els_p             = 64,
  localparam int cce_id_w    = (num_cce_p > 1) ? $clog2(num_cce_p) : 1,
  localparam int lce_id_w    = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
  localparam int way_w       = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1,
  localparam int block_bits  = 8 * block_size_in_bytes_p,
  localparam int req_w       = cce_id_w + lce_id_w + 1 + paddr_width_p + way_w + 1,
  localparam int resp_w      = cce_id_w + lce_id_w + 2 + paddr_width_p,
  localparam int data_resp_w = cce_id_w + lce_id_w + paddr_width_p + block_bits,
  localparam int cmd_w       = lce_id_w + cce_id_w + 2 + way_w + paddr_width_p,
  localparam int data_cmd_w  = lce_id_w + cce_id_w + way_w + 2 + paddr_width_p + block_bits
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [req_w-1:0]       lce_req_i,
  input  logic                   lce_req_v_i,
  output logic                   lce_req_ready_o,
  input  logic [resp_w-1:0]      lce_resp_i,
  input  logic                   lce_resp_v_i,
  output logic                   lce_resp_ready_o,
  input  logic [data_resp_w-1:0] lce_data_resp_i,
  input  logic                   lce_data_resp_v_i,
  output logic                   lce_data_resp_ready_o,
  output logic [cmd_w-1:0]       lce_cmd_o,
  output logic                   lce_cmd_v_o,
  input  logic                   lce_cmd_ready_i,
  output logic [data_cmd_w-1:0]  lce_data_cmd_o,
  output logic                   lce_data_cmd_v_o,
  input  logic                   lce_data_cmd_ready_i
`ifdef BP_ME_LCE_RESPONDER_STATS_EN
  ,
  output logic [31:0]            miss_count_o,
  output logic [31:0]            wb_count_o
`endif
);

  localparam int offset_w = $clog2(block_size_in_bytes_p);
  localparam int idx_w    = $clog2(mem_els_p);

  localparam logic [1:0] RESP_SYNC_ACK = 2'd0;
  localparam logic [1:0] RESP_COH_ACK  = 2'd1;
  localparam logic [1:0] CMD_SYNC      = 2'd0;
  localparam logic [1:0] CMD_WB        = 2'd1;
  localparam logic [1:0] COH_E         = 2'd2;
  localparam logic [1:0] COH_M         = 2'd3;

  typedef struct packed {
    logic [cce_id_w-1:0]      dst_id;
    logic [lce_id_w-1:0]      src_id;
    logic                     msg_type;
    logic [paddr_width_p-1:0] addr;
    logic [way_w-1:0]         lru_way;
    logic                     lru_dirty;
  } req_s;

  typedef struct packed {
    logic [cce_id_w-1:0]      dst_id;
    logic [lce_id_w-1:0]      src_id;
    logic [1:0]               msg_type;
    logic [paddr_width_p-1:0] addr;
  } resp_s;

  typedef struct packed {
    logic [cce_id_w-1:0]      dst_id;
    logic [lce_id_w-1:0]      src_id;
    logic [paddr_width_p-1:0] addr;
    logic [block_bits-1:0]    data;
  } data_resp_s;

  typedef struct packed {
    logic [lce_id_w-1:0]      dst_id;
    logic [cce_id_w-1:0]      src_id;
    logic [1:0]               msg_type;
    logic [way_w-1:0]         way;
    logic [paddr_width_p-1:0] addr;
  } cmd_s;

  typedef struct packed {
    logic [lce_id_w-1:0]      dst_id;
    logic [cce_id_w-1:0]      src_id;
    logic [way_w-1:0]         way;
    logic [1:0]               state;
    logic [paddr_width_p-1:0] addr;
    logic [block_bits-1:0]    data;
  } data_cmd_s;

  typedef enum logic [2:0] {
    SYNC_SEND, SYNC_WAIT, IDLE, WB_SEND, WB_WAIT, FILL_SEND, ACK_WAIT
  } state_e;

  req_s       req;
  resp_s      resp;
  data_resp_s data_resp;
  cmd_s       cmd;
  data_cmd_s  data_cmd;

  assign req       = lce_req_i;
  assign resp      = lce_resp_i;
  assign data_resp = lce_data_resp_i;
  assign lce_cmd_o      = cmd;
  assign lce_data_cmd_o = data_cmd;

  state_e state_r, state_n;
  logic   in_reset_r;

  logic [paddr_width_p-1:0] addr_r;
  logic                     wr_r;
  logic [way_w-1:0]         way_r;
  logic [block_bits-1:0]    mem [mem_els_p];

  logic req_hs, resp_hs, data_resp_hs, cmd_hs, data_cmd_hs;

  assign req_hs       = lce_req_v_i       & lce_req_ready_o;
  assign resp_hs      = lce_resp_v_i      & lce_resp_ready_o;
  assign data_resp_hs = lce_data_resp_v_i & lce_data_resp_ready_o;
  assign cmd_hs       = lce_cmd_v_o       & lce_cmd_ready_i;
  assign data_cmd_hs  = lce_data_cmd_v_o  & lce_data_cmd_ready_i;

  // in_reset_r masks every valid/ready for the cycle after a reset edge
  always_ff @(posedge clk_i) begin
    in_reset_r <= ~reset_n_i;
    if (!reset_n_i) state_r <= SYNC_SEND;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      SYNC_SEND: if (cmd_hs) state_n = SYNC_WAIT;
      SYNC_WAIT: if (resp_hs && resp.msg_type == RESP_SYNC_ACK) state_n = IDLE;
      IDLE:      if (req_hs) state_n = req.lru_dirty ? WB_SEND : FILL_SEND;
      WB_SEND:   if (cmd_hs) state_n = WB_WAIT;
      WB_WAIT:   if (data_resp_hs) state_n = FILL_SEND;
      FILL_SEND: if (data_cmd_hs) state_n = ACK_WAIT;
      ACK_WAIT:  if (resp_hs && resp.msg_type == RESP_COH_ACK) state_n = IDLE;
      default:   state_n = SYNC_SEND;
    endcase
  end

  always_comb begin
    lce_req_ready_o       = 1'b0;
    lce_resp_ready_o      = 1'b0;
    lce_data_resp_ready_o = 1'b0;
    lce_cmd_v_o           = 1'b0;
    lce_data_cmd_v_o      = 1'b0;

    cmd          = '0;
    cmd.dst_id   = lce_id_w'(lce_id_p);
    cmd.msg_type = (state_r == WB_SEND) ? CMD_WB : CMD_SYNC;
    if (state_r == WB_SEND) begin
      cmd.way  = way_r;
      cmd.addr = addr_r;
    end

    data_cmd        = '0;
    data_cmd.dst_id = lce_id_w'(lce_id_p);
    data_cmd.way    = way_r;
    data_cmd.state  = wr_r ? COH_M : COH_E;
    data_cmd.addr   = addr_r;
    data_cmd.data   = mem[addr_r[offset_w +: idx_w]];

    if (!in_reset_r) begin
      case (state_r)
        SYNC_SEND: lce_cmd_v_o           = 1'b1;
        SYNC_WAIT: lce_resp_ready_o      = 1'b1;
        IDLE:      lce_req_ready_o       = 1'b1;
        WB_SEND:   lce_cmd_v_o           = 1'b1;
        WB_WAIT:   lce_data_resp_ready_o = 1'b1;
        FILL_SEND: lce_data_cmd_v_o      = 1'b1;
        ACK_WAIT:  lce_resp_ready_o      = 1'b1;
        default:   ;
      endcase
    end
  end

  // Miss context is held for the whole transaction so payloads stay stable
  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      addr_r <= req.addr;
      wr_r   <= req.msg_type;
      way_r  <= req.lru_way;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < mem_els_p; i++) mem[i] <= '0;
    end else if (data_resp_hs) begin
      mem[data_resp.addr[offset_w +: idx_w]] <= data_resp.data;
    end
  end

`ifdef BP_ME_LCE_RESPONDER_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      miss_count_o <= '0;
      wb_count_o   <= '0;
    end else begin
      if (req_hs)       miss_count_o <= sat_inc(miss_count_o);
      if (data_resp_hs) wb_count_o   <= sat_inc(wb_count_o);
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{req.dst_id, req.src_id, resp.dst_id, resp.src_id, resp.addr,
                         data_resp.dst_id, data_resp.src_id, data_resp.addr};

endmodule

// File: tb/tb_bp_me_lce_responder.sv
// Scoreboard bench for bp_me_lce_responder: commands and fills are checked against
// expectations queued when the stimulus is driven.
module tb_bp_me_lce_responder;

  localparam int num_cce_p             = 1;
  localparam int num_lce_p             = 2;
  localparam int lce_id_p              = 1;
  localparam int paddr_width_p         = 16;
  localparam int lce_assoc_p           = 4;
  localparam int block_size_in_bytes_p = 8;
  localparam int mem_els_p             = 8;

  localparam logic [1:0] RESP_SYNC_ACK = 2'd0;
  localparam logic [1:0] RESP_COH_ACK  = 2'd1;
  localparam logic [1:0] RESP_INV_ACK  = 2'd2;
  localparam logic [1:0] CMD_SYNC      = 2'd0;
  localparam logic [1:0] CMD_WB        = 2'd1;
  localparam logic [1:0] ST_E          = 2'd2;
  localparam logic [1:0] ST_M          = 2'd3;

  typedef struct packed {
    logic [0:0] dst_id; logic [0:0] src_id; logic msg_type;
    logic [15:0] addr; logic [1:0] lru_way; logic lru_dirty;
  } req_s;
  typedef struct packed {
    logic [0:0] dst_id; logic [0:0] src_id; logic [1:0] msg_type; logic [15:0] addr;
  } resp_s;
  typedef struct packed {
    logic [0:0] dst_id; logic [0:0] src_id; logic [15:0] addr; logic [63:0] data;
  } data_resp_s;
  typedef struct packed {
    logic [0:0] dst_id; logic [0:0] src_id; logic [1:0] msg_type; logic [1:0] way; logic [15:0] addr;
  } cmd_s;
  typedef struct packed {
    logic [0:0] dst_id; logic [0:0] src_id; logic [1:0] way; logic [1:0] state;
    logic [15:0] addr; logic [63:0] data;
  } data_cmd_s;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  req_s       req = '0;
  logic       req_v = 1'b0, req_ready;
  resp_s      resp = '0;
  logic       resp_v = 1'b0, resp_ready;
  data_resp_s dresp = '0;
  logic       dresp_v = 1'b0, dresp_ready;
  cmd_s       cmd_o;
  logic       cmd_v, cmd_ready = 1'b0;
  data_cmd_s  fill_o;
  logic       fill_v, fill_ready = 1'b0;
`ifdef BP_ME_LCE_RESPONDER_STATS_EN
  logic [31:0] miss_count, wb_count;
`endif

  bp_me_lce_responder #(
    .num_cce_p(num_cce_p), .num_lce_p(num_lce_p), .lce_id_p(lce_id_p),
    .paddr_width_p(paddr_width_p), .lce_assoc_p(lce_assoc_p),
    .block_size_in_bytes_p(block_size_in_bytes_p), .mem_els_p(mem_els_p)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .lce_req_i(req), .lce_req_v_i(req_v), .lce_req_ready_o(req_ready),
    .lce_resp_i(resp), .lce_resp_v_i(resp_v), .lce_resp_ready_o(resp_ready),
    .lce_data_resp_i(dresp), .lce_data_resp_v_i(dresp_v), .lce_data_resp_ready_o(dresp_ready),
    .lce_cmd_o(cmd_o), .lce_cmd_v_o(cmd_v), .lce_cmd_ready_i(cmd_ready),
    .lce_data_cmd_o(fill_o), .lce_data_cmd_v_o(fill_v), .lce_data_cmd_ready_i(fill_ready)
`ifdef BP_ME_LCE_RESPONDER_STATS_EN
    , .miss_count_o(miss_count), .wb_count_o(wb_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] model_mem [mem_els_p];
  cmd_s      exp_cmd_q[$];
  data_cmd_s exp_fill_q[$];

  logic      prev_cmd_v = 1'b0, prev_cmd_hs = 1'b0, prev_fill_v = 1'b0, prev_fill_hs = 1'b0;
  cmd_s      prev_cmd = '0;
  data_cmd_s prev_fill = '0;

  // Output monitor: handshakes pop the scoreboard, held valids must keep their payload
  always @(negedge clk) begin
    if (cmd_v === 1'b1 && prev_cmd_v && !prev_cmd_hs) begin
      checks++;
      if (cmd_o !== prev_cmd) begin
        errors++; $display("FAIL cmd_stable: got %h, required %h", cmd_o, prev_cmd);
      end
    end
    if (fill_v === 1'b1 && prev_fill_v && !prev_fill_hs) begin
      checks++;
      if (fill_o !== prev_fill) begin
        errors++; $display("FAIL fill_stable: got %h, required %h", fill_o, prev_fill);
      end
    end
    if (cmd_v === 1'b1 && cmd_ready) begin
      checks++;
      if (exp_cmd_q.size() == 0) begin
        errors++; $display("FAIL cmd_unexpected: got %h, required no command", cmd_o);
      end else begin
        cmd_s e;
        e = exp_cmd_q.pop_front();
        if (cmd_o !== e) begin
          errors++; $display("FAIL cmd_payload: got %h, required %h", cmd_o, e);
        end
      end
    end
    if (fill_v === 1'b1 && fill_ready) begin
      checks++;
      if (exp_fill_q.size() == 0) begin
        errors++; $display("FAIL fill_unexpected: got %h, required no fill", fill_o);
      end else begin
        data_cmd_s e;
        e = exp_fill_q.pop_front();
        if (fill_o !== e) begin
          errors++; $display("FAIL fill_payload: got %h, required %h", fill_o, e);
        end
      end
    end
    prev_cmd_v   = (cmd_v === 1'b1);
    prev_cmd_hs  = (cmd_v === 1'b1) && cmd_ready;
    prev_cmd     = cmd_o;
    prev_fill_v  = (fill_v === 1'b1);
    prev_fill_hs = (fill_v === 1'b1) && fill_ready;
    prev_fill    = fill_o;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic cmd_s sync_cmd();
    cmd_s c;
    c = '0; c.dst_id = 1'(lce_id_p); c.msg_type = CMD_SYNC;
    return c;
  endfunction

  task automatic send_req(input logic wr, input logic [15:0] addr, input logic [1:0] way, input logic dirty);
    bit got;
    got = 1'b0;
    req = '0; req.src_id = 1'(lce_id_p); req.msg_type = wr; req.addr = addr;
    req.lru_way = way; req.lru_dirty = dirty; req_v = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = req_ready; tick(); end
    req_v = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL req_handshake: got timeout, required ready within 50 cycles"); end
  endtask

  task automatic send_resp(input logic [1:0] typ);
    bit got;
    got = 1'b0;
    resp = '0; resp.src_id = 1'(lce_id_p); resp.msg_type = typ; resp_v = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = resp_ready; tick(); end
    resp_v = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL resp_handshake: got timeout, required ready within 50 cycles"); end
  endtask

  task automatic send_data_resp(input logic [15:0] addr, input logic [63:0] data);
    bit got;
    got = 1'b0;
    dresp = '0; dresp.src_id = 1'(lce_id_p); dresp.addr = addr; dresp.data = data; dresp_v = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = dresp_ready; tick(); end
    dresp_v = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL data_resp_handshake: got timeout, required ready within 50 cycles"); end
  endtask

  task automatic accept_cmd();
    bit got;
    got = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = (cmd_v === 1'b1); tick(); end
    cmd_ready = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL cmd_handshake: got timeout, required valid within 50 cycles"); end
  endtask

  task automatic accept_fill(input bit bp);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      fill_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); got = (fill_v === 1'b1) && fill_ready; tick();
    end
    fill_ready = 1'b1;
    checks++;
    if (!got) begin errors++; $display("FAIL fill_handshake: got timeout, required fill within 200 cycles"); end
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0; req_v = 1'b0; resp_v = 1'b0; dresp_v = 1'b0; cmd_ready = 1'b0; fill_ready = 1'b0;
    exp_cmd_q.delete(); exp_fill_q.delete();
    repeat (cycles) tick();
    for (int i = 0; i < mem_els_p; i++) model_mem[i] = '0;
    reset_n = 1'b1;
    exp_cmd_q.push_back(sync_cmd());
    tick();
  endtask

  task automatic do_sync();
    accept_cmd();
    send_resp(RESP_SYNC_ACK);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL sync_to_idle: got req_ready=%b, required 1", req_ready); end
  endtask

  task automatic do_miss(input logic wr, input logic [15:0] addr, input logic [1:0] way,
                         input logic dirty, input logic [63:0] wb_data, input bit bp);
    data_cmd_s ef;
    cmd_s      ec;
    int        idx;
    idx = int'(addr[3 +: 3]);
    ef = '0; ef.dst_id = 1'(lce_id_p); ef.way = way; ef.state = wr ? ST_M : ST_E; ef.addr = addr;
    if (dirty) begin
      ec = '0; ec.dst_id = 1'(lce_id_p); ec.msg_type = CMD_WB; ec.way = way; ec.addr = addr;
      exp_cmd_q.push_back(ec);
      send_req(wr, addr, way, dirty);
      checks++;
      if (cmd_v !== 1'b1) begin errors++; $display("FAIL wb_cmd_valid: got %b, required 1", cmd_v); end
      accept_cmd();
      checks++;
      if (dresp_ready !== 1'b1) begin errors++; $display("FAIL wb_wait_ready: got %b, required 1", dresp_ready); end
      model_mem[idx] = wb_data;
      ef.data = model_mem[idx];
      exp_fill_q.push_back(ef);
      send_data_resp(addr, wb_data);
      checks++;
      if (fill_v !== 1'b1) begin errors++; $display("FAIL fill_after_wb: got %b, required 1", fill_v); end
    end else begin
      ef.data = model_mem[idx];
      exp_fill_q.push_back(ef);
      send_req(wr, addr, way, dirty);
      checks++;
      if (fill_v !== 1'b1) begin errors++; $display("FAIL clean_latency: got fill_v=%b, required 1", fill_v); end
    end
    accept_fill(bp);
    checks++;
    if (resp_ready !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL ack_wait: got resp_ready=%b req_ready=%b, required 1/0", resp_ready, req_ready);
    end
    send_resp(RESP_INV_ACK);
    checks++;
    if (resp_ready !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL ack_drop: got resp_ready=%b req_ready=%b, required 1/0", resp_ready, req_ready);
    end
    send_resp(RESP_COH_ACK);
    fill_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_return: got req_ready=%b, required 1", req_ready); end
    checks++;
    if (exp_fill_q.size() != 0) begin errors++; $display("FAIL fill_dropped: got %0d pending, required 0", exp_fill_q.size()); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (cmd_v !== 1'b0) begin errors++; $display("FAIL rst_cmd_v: got %b, required 0", cmd_v); end
    checks++; if (fill_v !== 1'b0) begin errors++; $display("FAIL rst_fill_v: got %b, required 0", fill_v); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
    checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL rst_resp_ready: got %b, required 0", resp_ready); end
    checks++; if (dresp_ready !== 1'b0) begin errors++; $display("FAIL rst_dresp_ready: got %b, required 0", dresp_ready); end
    for (int i = 0; i < mem_els_p; i++) model_mem[i] = '0;
    reset_n = 1'b1;
    exp_cmd_q.push_back(sync_cmd());
    tick();
    checks++; if (cmd_v !== 1'b1) begin errors++; $display("FAIL sync_first_cycle: got %b, required 1", cmd_v); end
    checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL sync_send_ready: got %b, required 0", resp_ready); end
  endtask

  task automatic test_sync();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd_v !== 1'b1) begin errors++; $display("FAIL sync_held: got %b, required 1", cmd_v); end
      tick();
    end
    accept_cmd();
    checks++;
    if (resp_ready !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL sync_wait: got resp_ready=%b req_ready=%b, required 1/0", resp_ready, req_ready);
    end
    send_resp(RESP_COH_ACK);
    checks++;
    if (resp_ready !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL sync_drop: got resp_ready=%b req_ready=%b, required 1/0", resp_ready, req_ready);
    end
    send_resp(RESP_SYNC_ACK);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL sync_ack_idle: got %b, required 1", req_ready); end
  endtask

  task automatic test_clean_read();
    do_miss(1'b0, 16'h0040, 2'd2, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic test_dirty_write();
    do_miss(1'b1, 16'h0080, 2'd1, 1'b1, {8{8'hA5}}, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    for (int n = 0; n < 8; n++) begin
      a = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFF8;
      do_miss(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 1'(n % 3 == 1),
              {$urandom, $urandom}, 1'b1);
    end
  endtask

  task automatic test_aliasing();
    do_miss(1'b1, 16'h0040, 2'd3, 1'b1, 64'h1122_3344_5566_7788, 1'b0);
    do_miss(1'b0, 16'h0000, 2'd0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cmd_s ec;
    ec = '0; ec.dst_id = 1'(lce_id_p); ec.msg_type = CMD_WB; ec.way = 2'd3; ec.addr = 16'h0010;
    exp_cmd_q.push_back(ec);
    send_req(1'b1, 16'h0010, 2'd3, 1'b1);
    accept_cmd();
    checks++;
    if (dresp_ready !== 1'b1) begin errors++; $display("FAIL mid_wb_wait: got %b, required 1", dresp_ready); end
    reset_n = 1'b0; exp_cmd_q.delete(); exp_fill_q.delete();
    tick();
    checks++;
    if (dresp_ready !== 1'b0 || cmd_v !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: got dresp_ready=%b cmd_v=%b, required 0/0", dresp_ready, cmd_v);
    end
    for (int i = 0; i < mem_els_p; i++) model_mem[i] = '0;
    reset_n = 1'b1;
    exp_cmd_q.push_back(sync_cmd());
    tick();
    checks++;
    if (cmd_v !== 1'b1 || dresp_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_sync: got cmd_v=%b dresp_ready=%b, required 1/0", cmd_v, dresp_ready);
    end
    do_sync();
    do_miss(1'b0, 16'h0000, 2'd0, 1'b0, 64'h0, 1'b0);
    do_miss(1'b0, 16'h0080, 2'd1, 1'b0, 64'h0, 1'b0);
  endtask

`ifdef BP_ME_LCE_RESPONDER_STATS_EN
  task automatic test_stats();
    do_reset(2);
    checks++;
    if (miss_count !== 32'd0 || wb_count !== 32'd0) begin
      errors++; $display("FAIL stats_reset: got %0d/%0d, required 0/0", miss_count, wb_count);
    end
    do_sync();
    do_miss(1'b0, 16'h0008, 2'd0, 1'b0, 64'h0, 1'b0);
    do_miss(1'b1, 16'h0018, 2'd1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0);
    do_miss(1'b0, 16'h0018, 2'd2, 1'b0, 64'h0, 1'b0);
    checks++;
    if (miss_count !== 32'd3) begin errors++; $display("FAIL stats_miss: got %0d, required 3", miss_count); end
    checks++;
    if (wb_count !== 32'd1) begin errors++; $display("FAIL stats_wb: got %0d, required 1", wb_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_sync();
    test_clean_read();
    test_dirty_write();
    test_backpressure();
    test_aliasing();
    test_reset_mid();
`ifdef BP_ME_LCE_RESPONDER_STATS_EN
    test_stats();
`endif
    checks++;
    if (exp_cmd_q.size() != 0) begin errors++; $display("FAIL cmd_pending: got %0d, required 0", exp_cmd_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
